axis_traffic_gen: RTL and testbench
===================================

Name: axis_traffic_gen

Overview:
- Synthetic AXI-Stream packet source. One instance drives each mesh input endpoint (axis_in_*) in the user clock domain, for bring-up, bandwidth measurement and end-to-end ordering checks.
- Emits a programmed number of fixed-length packets.
- Destinations rotate round-robin across endpoints.
- Each beat carries source id, packet sequence number and beat index, so a downstream checker can detect loss, reordering and corruption.

Parameters:
- TID_WIDTH, 2, width of axis_tid.
- TDEST_WIDTH, 4, width of axis_tdest.
- TDATA_WIDTH, 512, width of axis_tdata. Must be >= 64.
- SRC_ID, 0, this endpoint's id, embedded in the payload.
- NUM_DESTS, 4, number of mesh endpoints. Must be >= 2 and <= 2**TDEST_WIDTH.
- SKIP_SELF, 1, when 1 the destination rotation never selects SRC_ID.
- MAX_PKT_LEN, 16, maximum beats per packet. LEN_WIDTH = $clog2(MAX_PKT_LEN+1) is a localparam.

Ports:
- clk  input  1  user clock; all logic is on the rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- start  input  1  single-cycle pulse that begins a run.
- stop  input  1  single-cycle pulse requesting a graceful stop.
- cfg_num_pkts  input  32  packets per run; 0 means unlimited (runs until stop).
- cfg_pkt_len  input  LEN_WIDTH  beats per packet.
- cfg_tid  input  TID_WIDTH  value driven on axis_tid for the whole run.
- busy  output  1  high while in SEND.
- done  output  1  high in DONE state.
- pkts_sent  output  32  count of packets completed in the current run.
- axis_tvalid  output  1  AXIS valid.
- axis_tready  input  1  AXIS ready.
- axis_tdata  output  TDATA_WIDTH  AXIS data.
- axis_tlast  output  1  AXIS last.
- axis_tid  output  TID_WIDTH  AXIS id.
- axis_tdest  output  TDEST_WIDTH  AXIS destination.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; busy, done, axis_tvalid, axis_tlast = 0; pkts_sent, beat counter, sequence number, tdata, tid, tdest = 0; stop_pending = 0.
- States: IDLE, SEND, DONE.
- Entering SEND: start in IDLE or DONE moves to SEND on the next edge. On that edge:
  - cfg is latched; len_q = max(1, min(cfg_pkt_len, MAX_PKT_LEN)).
  - done, pkts_sent and seq are cleared.
  - First dest = (SRC_ID+1) mod NUM_DESTS.
  - axis_tvalid rises one cycle after start. cfg is not sampled again during the run.
- start while in SEND is ignored.
- Handshake:
  - A beat transfers when axis_tvalid && axis_tready.
  - While axis_tvalid=1 and axis_tready=0, tdata, tlast, tid and tdest hold stable.
  - axis_tvalid never depends combinationally on axis_tready.
  - All outputs are registered.
- Payload per beat:
  - tdata[15:0] = beat index, 0..len_q-1.
  - tdata[31:16] = SRC_ID.
  - tdata[63:32] = seq, the packet sequence number of this run starting at 0.
  - Upper bits = 0.
  - tlast = 1 exactly on beat len_q-1.
  - tdest and tid are constant within a packet.
- Packet boundary: a transfer with tlast=1 completes a packet. On that transfer:
  - pkts_sent increments, saturating at 2**32-1.
  - seq increments and wraps mod 2**32.
  - beat index returns to 0.
  - dest advances to (dest+1) mod NUM_DESTS; if SKIP_SELF and the result equals SRC_ID, it advances once more.
  - The next packet's first beat is presented on the following cycle with no bubble.
- Termination: on that tlast transfer, when pkts_sent+1 == cfg_num_pkts (nonzero) or stop_pending=1, the block moves to DONE, clears axis_tvalid and sets done.
- Stop:
  - In SEND, stop sets stop_pending. The current packet always completes; packets are never truncated.
  - If stop coincides with the tlast transfer, that packet is the final one.
  - stop in IDLE or DONE is ignored.
  - stop_pending clears on entry to DONE.
- DONE: done=1 and busy=0. Holds until the next start, or until reset. pkts_sent holds its final value until the next start.
- Reset mid-packet: the packet is abandoned. axis_tvalid drops asynchronously; no tlast is emitted.

Test Plan:
- SRC_ID=0, NUM_DESTS=4, cfg_num_pkts=3, cfg_pkt_len=2, tready=1 -> 6 beats back-to-back; tdest sequence 1,1,2,2,3,3; tlast on beats 1,3,5; done rises on the cycle after the 6th transfer; pkts_sent=3.
- Same configuration, tready toggling 1,0,0,1,… -> payload and tdest stable while stalled; identical beat stream to the first case; no dropped or duplicated beats.
- SRC_ID=2, NUM_DESTS=4, SKIP_SELF=1, cfg_num_pkts=4, cfg_pkt_len=1 -> tdest sequence 3,0,1,3; tdata[63:32] = 0,1,2,3.
- cfg_num_pkts=0, cfg_pkt_len=4, stop pulsed during beat 1 of packet 5 -> beats 2 and 3 of packet 5 still sent; done afterwards; pkts_sent=6.
- cfg_pkt_len=0 -> single-beat packets. cfg_pkt_len=31 with MAX_PKT_LEN=16 -> 16-beat packets.
- rst_n low while tvalid=1 mid-packet -> tvalid=0 immediately; after release, state is IDLE; next start gives seq 0 and beat index 0.

Source files
------------

// File: rtl/axis_traffic_gen.sv
// Synthetic AXI-Stream packet source: fixed-length packets, round-robin destinations,
// and a self-describing payload (beat index, source id, sequence number) on every beat.
module axis_traffic_gen #(
  parameter int TID_WIDTH   = 2,
  parameter int TDEST_WIDTH = 4,
  parameter int TDATA_WIDTH = 512,
  parameter int SRC_ID      = 0,
  parameter int NUM_DESTS   = 4,
  parameter int SKIP_SELF   = 1,
  parameter int MAX_PKT_LEN = 16,
  localparam int LEN_WIDTH  = $clog2(MAX_PKT_LEN + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   stop,
  input  logic [31:0]            cfg_num_pkts,
  input  logic [LEN_WIDTH-1:0]   cfg_pkt_len,
  input  logic [TID_WIDTH-1:0]   cfg_tid,
  output logic                   busy,
  output logic                   done,
  output logic [31:0]            pkts_sent,
  output logic                   axis_tvalid,
  input  logic                   axis_tready,
  output logic [TDATA_WIDTH-1:0] axis_tdata,
  output logic                   axis_tlast,
  output logic [TID_WIDTH-1:0]   axis_tid,
  output logic [TDEST_WIDTH-1:0] axis_tdest
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [TDEST_WIDTH-1:0] FIRST_DEST = TDEST_WIDTH'((SRC_ID + 1) % NUM_DESTS);

  logic [1:0]             state_q, state_d;
  logic [LEN_WIDTH-1:0]   len_q, len_d;
  logic [31:0]            num_pkts_q, num_pkts_d;
  logic [TID_WIDTH-1:0]   tid_q, tid_d;
  logic [LEN_WIDTH-1:0]   beat_q, beat_d;
  logic [31:0]            seq_q, seq_d;
  logic [TDEST_WIDTH-1:0] dest_q, dest_d;
  logic [31:0]            pkts_sent_q, pkts_sent_d;
  logic                   stop_pending_q, stop_pending_d;
  logic                   tvalid_q, tvalid_d;
  logic                   tlast_q, tlast_d;
  logic [TDATA_WIDTH-1:0] tdata_q, tdata_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  logic [LEN_WIDTH-1:0]   len_new;
  logic [LEN_WIDTH-1:0]   beat_nxt;
  logic [31:0]            seq_nxt;
  logic                   last_pkt;

  function automatic logic [TDATA_WIDTH-1:0] build_beat(input logic [LEN_WIDTH-1:0] beat,
                                                        input logic [31:0] seq);
    logic [TDATA_WIDTH-1:0] d;
    d        = '0;
    d[15:0]  = 16'(beat);
    d[31:16] = 16'(SRC_ID);
    d[63:32] = seq;
    return d;
  endfunction

  function automatic logic [LEN_WIDTH-1:0] clamp_len(input logic [LEN_WIDTH-1:0] l);
    if (l == '0) return LEN_WIDTH'(1);
    if (l > LEN_WIDTH'(MAX_PKT_LEN)) return LEN_WIDTH'(MAX_PKT_LEN);
    return l;
  endfunction

  function automatic logic [TDEST_WIDTH-1:0] wrap_inc(input logic [TDEST_WIDTH-1:0] d);
    if (d == TDEST_WIDTH'(NUM_DESTS - 1)) return '0;
    return d + TDEST_WIDTH'(1);
  endfunction

  // Skipping self needs at most one extra step since NUM_DESTS >= 2.
  function automatic logic [TDEST_WIDTH-1:0] next_dest(input logic [TDEST_WIDTH-1:0] d);
    logic [TDEST_WIDTH-1:0] n;
    n = wrap_inc(d);
    if (SKIP_SELF != 0 && n == TDEST_WIDTH'(SRC_ID)) n = wrap_inc(n);
    return n;
  endfunction

  always_comb begin
    state_d        = state_q;
    len_d          = len_q;
    num_pkts_d     = num_pkts_q;
    tid_d          = tid_q;
    beat_d         = beat_q;
    seq_d          = seq_q;
    dest_d         = dest_q;
    pkts_sent_d    = pkts_sent_q;
    stop_pending_d = stop_pending_q;
    tvalid_d       = tvalid_q;
    tlast_d        = tlast_q;
    tdata_d        = tdata_q;
    busy_d         = busy_q;
    done_d         = done_q;
    len_new        = clamp_len(cfg_pkt_len);
    beat_nxt       = beat_q + LEN_WIDTH'(1);
    seq_nxt        = seq_q + 32'd1;
    last_pkt       = ((num_pkts_q != 32'd0) && ({1'b0, pkts_sent_q} + 33'd1 == {1'b0, num_pkts_q}))
                     || stop_pending_q || stop;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d        = ST_SEND;
          len_d          = len_new;
          num_pkts_d     = cfg_num_pkts;
          tid_d          = cfg_tid;
          beat_d         = '0;
          seq_d          = '0;
          dest_d         = FIRST_DEST;
          pkts_sent_d    = '0;
          stop_pending_d = 1'b0;
          tvalid_d       = 1'b1;
          tlast_d        = (len_new == LEN_WIDTH'(1));
          tdata_d        = build_beat('0, 32'd0);
          busy_d         = 1'b1;
          done_d         = 1'b0;
        end
      end
      ST_SEND: begin
        if (stop) stop_pending_d = 1'b1;
        if (tvalid_q && axis_tready) begin
          if (tlast_q) begin
            pkts_sent_d = (pkts_sent_q == '1) ? pkts_sent_q : pkts_sent_q + 32'd1;
            seq_d       = seq_nxt;
            beat_d      = '0;
            dest_d      = next_dest(dest_q);
            if (last_pkt) begin
              state_d        = ST_DONE;
              tvalid_d       = 1'b0;
              tlast_d        = 1'b0;
              busy_d         = 1'b0;
              done_d         = 1'b1;
              stop_pending_d = 1'b0;
            end else begin
              tdata_d = build_beat('0, seq_nxt);
              tlast_d = (len_q == LEN_WIDTH'(1));
            end
          end else begin
            beat_d  = beat_nxt;
            tdata_d = build_beat(beat_nxt, seq_q);
            tlast_d = (beat_nxt == len_q - LEN_WIDTH'(1));
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      len_q          <= LEN_WIDTH'(1);
      num_pkts_q     <= '0;
      tid_q          <= '0;
      beat_q         <= '0;
      seq_q          <= '0;
      dest_q         <= '0;
      pkts_sent_q    <= '0;
      stop_pending_q <= 1'b0;
      tvalid_q       <= 1'b0;
      tlast_q        <= 1'b0;
      tdata_q        <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      len_q          <= len_d;
      num_pkts_q     <= num_pkts_d;
      tid_q          <= tid_d;
      beat_q         <= beat_d;
      seq_q          <= seq_d;
      dest_q         <= dest_d;
      pkts_sent_q    <= pkts_sent_d;
      stop_pending_q <= stop_pending_d;
      tvalid_q       <= tvalid_d;
      tlast_q        <= tlast_d;
      tdata_q        <= tdata_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign pkts_sent   = pkts_sent_q;
  assign axis_tvalid = tvalid_q;
  assign axis_tdata  = tdata_q;
  assign axis_tlast  = tlast_q;
  assign axis_tid    = tid_q;
  assign axis_tdest  = dest_q;

endmodule

// File: tb/tb_axis_traffic_gen.sv
// Directed bench for axis_traffic_gen: two instances (SRC_ID 0 and 2) share clock and
// configuration; sel chooses which one is started and observed.
module tb_axis_traffic_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, stop, tready, sel;
  logic [31:0] cfg_num_pkts;
  logic [4:0]  cfg_pkt_len;
  logic [1:0]  cfg_tid;

  logic         a_busy, a_done, a_tvalid, a_tlast;
  logic [31:0]  a_pkts;
  logic [511:0] a_tdata;
  logic [1:0]   a_tid;
  logic [3:0]   a_tdest;
  logic         b_busy, b_done, b_tvalid, b_tlast;
  logic [31:0]  b_pkts;
  logic [511:0] b_tdata;
  logic [1:0]   b_tid;
  logic [3:0]   b_tdest;

  axis_traffic_gen u_a (
    .clk(clk), .rst_n(rst_n), .start(start && !sel), .stop(stop),
    .cfg_num_pkts(cfg_num_pkts), .cfg_pkt_len(cfg_pkt_len), .cfg_tid(cfg_tid),
    .busy(a_busy), .done(a_done), .pkts_sent(a_pkts),
    .axis_tvalid(a_tvalid), .axis_tready(tready), .axis_tdata(a_tdata),
    .axis_tlast(a_tlast), .axis_tid(a_tid), .axis_tdest(a_tdest)
  );

  axis_traffic_gen #(.SRC_ID(2)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start && sel), .stop(stop),
    .cfg_num_pkts(cfg_num_pkts), .cfg_pkt_len(cfg_pkt_len), .cfg_tid(cfg_tid),
    .busy(b_busy), .done(b_done), .pkts_sent(b_pkts),
    .axis_tvalid(b_tvalid), .axis_tready(tready), .axis_tdata(b_tdata),
    .axis_tlast(b_tlast), .axis_tid(b_tid), .axis_tdest(b_tdest)
  );

  logic         o_valid, o_last, o_done, o_busy;
  logic [511:0] o_data;
  logic [3:0]   o_dest;
  logic [1:0]   o_tid;
  logic [31:0]  o_pkts;
  assign o_valid = sel ? b_tvalid : a_tvalid;
  assign o_last  = sel ? b_tlast  : a_tlast;
  assign o_done  = sel ? b_done   : a_done;
  assign o_busy  = sel ? b_busy   : a_busy;
  assign o_data  = sel ? b_tdata  : a_tdata;
  assign o_dest  = sel ? b_tdest  : a_tdest;
  assign o_tid   = sel ? b_tid    : a_tid;
  assign o_pkts  = sel ? b_pkts   : a_pkts;

  int total = 0;
  int bad   = 0;

  logic [63:0] b_data[$];
  logic        b_last[$];
  logic [3:0]  b_dest[$];
  logic [1:0]  b_tidq[$];
  logic        b_hi[$];
  logic        c_v[$];
  logic        c_r[$];
  logic [63:0] c_d[$];
  logic        c_l[$];
  logic [3:0]  c_t[$];
  int          done_cyc, last_xfer;
  logic        timed_out;

  // Called at a negedge: pulses start for one edge, then scrambles cfg so any resampling shows.
  task automatic do_start(input logic s, input logic [31:0] n, input logic [4:0] l, input logic [1:0] t);
    sel = s; cfg_num_pkts = n; cfg_pkt_len = l; cfg_tid = t; start = 1'b1;
    @(negedge clk);
    start = 1'b0; cfg_num_pkts = 32'd1; cfg_pkt_len = 5'd7; cfg_tid = 2'b01;
  endtask

  // Records outputs every negedge until done; mode 1 drives tready 1,0,0,1 repeating.
  task automatic collect(input int max_cyc, input int mode, input int stop_at);
    b_data.delete(); b_last.delete(); b_dest.delete(); b_tidq.delete(); b_hi.delete();
    c_v.delete(); c_r.delete(); c_d.delete(); c_l.delete(); c_t.delete();
    done_cyc = -1; last_xfer = -1; timed_out = 1'b0;
    for (int c = 0; c < max_cyc; c++) begin
      stop = 1'b0;
      tready = (mode == 0) ? 1'b1 : ((c % 4 == 0) || (c % 4 == 3));
      c_v.push_back(o_valid); c_r.push_back(tready); c_d.push_back(o_data[63:0]);
      c_l.push_back(o_last); c_t.push_back(o_dest);
      if (o_done) begin
        done_cyc = c;
        break;
      end
      if (stop_at >= 0 && o_valid && b_data.size() == stop_at) stop = 1'b1;
      if (o_valid && tready) begin
        b_data.push_back(o_data[63:0]); b_last.push_back(o_last); b_dest.push_back(o_dest);
        b_tidq.push_back(o_tid); b_hi.push_back(o_data[511:64] == '0);
        last_xfer = c;
      end
      @(negedge clk);
    end
    if (done_cyc < 0) timed_out = 1'b1;
    stop = 1'b0;
  endtask

  task automatic test_reset();
    total++; if (a_tvalid !== 1'b0 || a_tlast !== 1'b0) begin bad++; $display("FAIL reset_valid_last got v=%b l=%b want 0 0", a_tvalid, a_tlast); end
    total++; if (a_busy !== 1'b0 || a_done !== 1'b0) begin bad++; $display("FAIL reset_busy_done got %b %b want 0 0", a_busy, a_done); end
    total++; if (a_pkts !== 32'd0) begin bad++; $display("FAIL reset_pkts got %0d want 0", a_pkts); end
    total++; if (a_tdata !== '0 || a_tid !== 2'd0 || a_tdest !== 4'd0) begin bad++; $display("FAIL reset_payload got data=%h tid=%0d dest=%0d want 0", a_tdata[63:0], a_tid, a_tdest); end
  endtask

  task automatic test_basic();
    logic [63:0] e;
    logic        el;
    do_start(1'b0, 32'd3, 5'd2, 2'b10);
    collect(200, 0, -1);
    total++; if (timed_out) begin bad++; $display("FAIL basic_timeout got no done want done"); end
    total++; if (c_v[0] !== 1'b1) begin bad++; $display("FAIL basic_valid_after_start got %b want 1", c_v[0]); end
    total++; if (b_data.size() != 6) begin bad++; $display("FAIL basic_beats got %0d want 6", b_data.size()); end
    for (int i = 0; i < b_data.size() && i < 6; i++) begin
      e  = {32'(i / 2), 16'd0, 16'(i % 2)};
      el = (i % 2 == 1);
      total++; if (b_data[i] !== e) begin bad++; $display("FAIL basic_data[%0d] got %h want %h", i, b_data[i], e); end
      total++; if (b_last[i] !== el) begin bad++; $display("FAIL basic_last[%0d] got %b want %b", i, b_last[i], el); end
      total++; if (b_dest[i] !== 4'(i / 2 + 1)) begin bad++; $display("FAIL basic_dest[%0d] got %0d want %0d", i, b_dest[i], i / 2 + 1); end
      total++; if (b_tidq[i] !== 2'b10) begin bad++; $display("FAIL basic_tid[%0d] got %0d want 2", i, b_tidq[i]); end
      total++; if (b_hi[i] !== 1'b1) begin bad++; $display("FAIL basic_upper_zero[%0d] got %b want 1", i, b_hi[i]); end
    end
    total++; if (done_cyc != last_xfer + 1) begin bad++; $display("FAIL basic_done_timing got %0d want %0d", done_cyc, last_xfer + 1); end
    total++; if (a_pkts !== 32'd3) begin bad++; $display("FAIL basic_pkts got %0d want 3", a_pkts); end
    total++; if (a_busy !== 1'b0 || a_tvalid !== 1'b0) begin bad++; $display("FAIL basic_idle_after got busy=%b v=%b want 0 0", a_busy, a_tvalid); end
  endtask

  task automatic test_stall();
    logic [63:0] e;
    logic        el;
    stop = 1'b1;  // stop while in DONE must be ignored
    @(negedge clk);
    stop = 1'b0;
    do_start(1'b0, 32'd3, 5'd2, 2'b10);
    collect(300, 1, -1);
    total++; if (timed_out) begin bad++; $display("FAIL stall_timeout got no done want done"); end
    total++; if (b_data.size() != 6) begin bad++; $display("FAIL stall_beats got %0d want 6", b_data.size()); end
    for (int i = 0; i < b_data.size() && i < 6; i++) begin
      e  = {32'(i / 2), 16'd0, 16'(i % 2)};
      el = (i % 2 == 1);
      total++; if (b_data[i] !== e || b_last[i] !== el || b_dest[i] !== 4'(i / 2 + 1)) begin
        bad++; $display("FAIL stall_beat[%0d] got d=%h l=%b t=%0d want d=%h l=%b t=%0d", i, b_data[i], b_last[i], b_dest[i], e, el, i / 2 + 1);
      end
    end
    for (int c = 1; c < c_v.size(); c++) begin
      if (c_v[c-1] && !c_r[c-1]) begin
        total++; if (c_v[c] !== 1'b1 || c_d[c] !== c_d[c-1] || c_l[c] !== c_l[c-1] || c_t[c] !== c_t[c-1]) begin
          bad++; $display("FAIL stall_hold[%0d] got v=%b d=%h l=%b t=%0d want v=1 d=%h l=%b t=%0d", c, c_v[c], c_d[c], c_l[c], c_t[c], c_d[c-1], c_l[c-1], c_t[c-1]);
        end
      end
    end
    total++; if (a_pkts !== 32'd3) begin bad++; $display("FAIL stall_pkts got %0d want 3", a_pkts); end
  endtask

  task automatic test_skip_self();
    logic [3:0]  exp_dest[4] = '{4'd3, 4'd0, 4'd1, 4'd3};
    logic [63:0] e;
    do_start(1'b1, 32'd4, 5'd1, 2'b00);
    collect(200, 0, -1);
    total++; if (timed_out) begin bad++; $display("FAIL skip_timeout got no done want done"); end
    total++; if (b_data.size() != 4) begin bad++; $display("FAIL skip_beats got %0d want 4", b_data.size()); end
    for (int i = 0; i < b_data.size() && i < 4; i++) begin
      e = {32'(i), 16'd2, 16'd0};
      total++; if (b_dest[i] !== exp_dest[i]) begin bad++; $display("FAIL skip_dest[%0d] got %0d want %0d", i, b_dest[i], exp_dest[i]); end
      total++; if (b_data[i] !== e || b_last[i] !== 1'b1) begin bad++; $display("FAIL skip_data[%0d] got %h l=%b want %h l=1", i, b_data[i], b_last[i], e); end
    end
    total++; if (b_pkts !== 32'd4) begin bad++; $display("FAIL skip_pkts got %0d want 4", b_pkts); end
  endtask

  task automatic test_stop();
    logic [63:0] e;
    logic        el;
    do_start(1'b0, 32'd0, 5'd4, 2'b00);
    collect(400, 0, 21);
    total++; if (timed_out) begin bad++; $display("FAIL stop_timeout got no done want done"); end
    total++; if (b_data.size() != 24) begin bad++; $display("FAIL stop_beats got %0d want 24", b_data.size()); end
    for (int i = 0; i < b_data.size() && i < 24; i++) begin
      e  = {32'(i / 4), 16'd0, 16'(i % 4)};
      el = (i % 4 == 3);
      total++; if (b_data[i] !== e || b_last[i] !== el || b_dest[i] !== 4'(1 + (i / 4) % 3)) begin
        bad++; $display("FAIL stop_beat[%0d] got d=%h l=%b t=%0d want d=%h l=%b t=%0d", i, b_data[i], b_last[i], b_dest[i], e, el, 1 + (i / 4) % 3);
      end
    end
    total++; if (a_pkts !== 32'd6 || a_done !== 1'b1) begin bad++; $display("FAIL stop_final got pkts=%0d done=%b want 6 1", a_pkts, a_done); end
  endtask

  task automatic test_len_clamp();
    do_start(1'b0, 32'd2, 5'd0, 2'b00);
    collect(100, 0, -1);
    total++; if (b_data.size() != 2 || timed_out) begin bad++; $display("FAIL len0_beats got %0d want 2", b_data.size()); end
    for (int i = 0; i < b_data.size() && i < 2; i++) begin
      total++; if (b_last[i] !== 1'b1 || b_data[i][15:0] !== 16'd0) begin bad++; $display("FAIL len0_beat[%0d] got l=%b idx=%0d want l=1 idx=0", i, b_last[i], b_data[i][15:0]); end
    end
    do_start(1'b0, 32'd1, 5'd31, 2'b00);
    collect(100, 0, -1);
    total++; if (b_data.size() != 16 || timed_out) begin bad++; $display("FAIL len31_beats got %0d want 16", b_data.size()); end
    for (int i = 0; i < b_data.size() && i < 16; i++) begin
      total++; if (b_last[i] !== (i == 15) || b_data[i][15:0] !== 16'(i)) begin bad++; $display("FAIL len31_beat[%0d] got l=%b idx=%0d want l=%b idx=%0d", i, b_last[i], b_data[i][15:0], (i == 15), i); end
    end
  endtask

  task automatic test_reset_mid();
    do_start(1'b0, 32'd0, 5'd4, 2'b11);
    tready = 1'b1;
    repeat (5) @(negedge clk);
    total++; if (o_valid !== 1'b1) begin bad++; $display("FAIL midrst_pre_valid got %b want 1", o_valid); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (a_tvalid !== 1'b0 || a_tlast !== 1'b0 || a_busy !== 1'b0) begin bad++; $display("FAIL midrst_async got v=%b l=%b busy=%b want 0 0 0", a_tvalid, a_tlast, a_busy); end
    total++; if (a_pkts !== 32'd0 || a_tdata !== '0) begin bad++; $display("FAIL midrst_clear got pkts=%0d data=%h want 0", a_pkts, a_tdata[63:0]); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (a_busy !== 1'b0 || a_done !== 1'b0 || a_tvalid !== 1'b0) begin bad++; $display("FAIL midrst_idle got busy=%b done=%b v=%b want 0 0 0", a_busy, a_done, a_tvalid); end
    do_start(1'b0, 32'd1, 5'd2, 2'b00);
    collect(100, 0, -1);
    total++; if (b_data.size() != 2 || timed_out) begin bad++; $display("FAIL midrst_beats got %0d want 2", b_data.size()); end
    if (b_data.size() > 0) begin
      total++; if (b_data[0] !== 64'd0) begin bad++; $display("FAIL midrst_first got %h want 0", b_data[0]); end
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; tready = 1'b0; sel = 1'b0;
    cfg_num_pkts = '0; cfg_pkt_len = '0; cfg_tid = '0;
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_basic();
    test_stall();
    test_skip_self();
    sel = 1'b0;
    test_stop();
    test_len_clamp();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got running want finished");
    $fatal(1, "bench timeout");
  end

endmodule
